dmem_arbiter: RTL and testbench

- Shares the single data-memory port between the RV32I core's load/store path and an external DMA/debug requester.
- Handles multi-cycle memory: issues registered memory requests, waits for `mem_ack`, and routes read data back to the owner.
- Stalls the core via `core_stall` while its access is pending.
- Enforces DMA fairness and aborts hung accesses with a timeout.

---
 rtl/dmem_arbiter.sv | 99 +++++++++
 tb/tb_dmem_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: core/DMA data-memory port arbiter with ack wait and timeout abort; DMEM_ARB_RR_EN selects round-robin contention
module dmem_arbiter #(
    parameter int MAX_CORE_BURST = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [2:0]  core_mode,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic [31:0] core_rdata,
    output logic        core_stall,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [2:0]  dma_mode,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic [31:0] dma_rdata,
    output logic        dma_done,
    output logic        mem_req,
    output logic        mem_we,
    output logic [2:0]  mem_mode,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        bus_err
);
    typedef enum logic [1:0] {IDLE, CORE_BUSY, DMA_BUSY} state_t;
    state_t state, state_n;
    logic [7:0] tmo;
    logic [31:0] core_q;
    logic idle, abort, finish, grant_core, grant_dma;
    assign idle = state == IDLE;
    assign abort = !idle && !mem_ack && tmo == 8'(TIMEOUT_CYCLES - 1);
    assign finish = !idle && (mem_ack || abort);
`ifdef DMEM_ARB_RR_EN
    logic last_dma;
    assign grant_core = idle && core_req && (!dma_req || last_dma);
`else
    logic [3:0] burst;
    assign grant_core = idle && core_req && (!dma_req || burst < 4'(MAX_CORE_BURST));
`endif
    assign grant_dma = idle && dma_req && !grant_core;
    always_comb begin
        state_n = state;
        if (grant_core) state_n = CORE_BUSY;
        else if (grant_dma) state_n = DMA_BUSY;
        else if (finish) state_n = IDLE;
    end
    assign core_stall = core_req && !(state == CORE_BUSY && finish);
    // an aborted core access returns zero in the abort cycle
    assign core_rdata = state == CORE_BUSY && mem_ack ? mem_rdata :
                        state == CORE_BUSY && abort ? '0 : core_q;
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            tmo <= '0;
            core_q <= '0;
            mem_req <= 1'b0;
            mem_we <= 1'b0;
            mem_mode <= '0;
            mem_addr <= '0;
            mem_wdata <= '0;
            dma_rdata <= '0;
            dma_done <= 1'b0;
            bus_err <= 1'b0;
`ifdef DMEM_ARB_RR_EN
            last_dma <= 1'b1;
`else
            burst <= '0;
`endif
        end else begin
            state <= state_n;
            dma_done <= state == DMA_BUSY && finish;
            bus_err <= bus_err || abort;
            tmo <= idle || finish ? '0 : tmo + 8'd1;
            if (grant_core || grant_dma) begin
                mem_req <= 1'b1;
                mem_we <= grant_core ? core_we : dma_we;
                mem_mode <= grant_core ? core_mode : dma_mode;
                mem_addr <= grant_core ? core_addr : dma_addr;
                mem_wdata <= grant_core ? core_wdata : dma_wdata;
            end else if (finish) begin
                mem_req <= 1'b0;
            end
            if (state == CORE_BUSY && finish) core_q <= abort ? '0 : mem_rdata;
            if (state == DMA_BUSY && (abort || mem_ack && !mem_we)) dma_rdata <= abort ? '0 : mem_rdata;
`ifdef DMEM_ARB_RR_EN
            if (grant_core || grant_dma) last_dma <= grant_dma;
`else
            if (grant_dma || idle && !dma_req) burst <= '0;
            else if (grant_core && dma_req && burst != 4'd15) burst <= burst + 4'd1;
`endif
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter with a programmable-latency memory model
module tb_dmem_arbiter;
    logic clk = 0, reset = 0;
    logic core_req = 0, core_we = 0, dma_req = 0, dma_we = 0, mem_ack = 0;
    logic [2:0] core_mode = 0, dma_mode = 0;
    logic [31:0] core_addr = 0, core_wdata = 0, dma_addr = 0, dma_wdata = 0, mem_rdata = 0;
    logic [31:0] core_rdata, dma_rdata, mem_addr, mem_wdata;
    logic core_stall, dma_done, mem_req, mem_we, bus_err;
    logic [2:0] mem_mode;
    int checks = 0, errors = 0;
    int delay = 0, cnt = 0;
    logic force_ack = 0, stall_seen = 0;
    logic [31:0] rd_val = 0;
    typedef struct packed {
        logic we;
        logic [2:0] mode;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [7:0] len;
    } acc_t;
    acc_t mem_q[$], cur;
    logic [31:0] core_q[$], dma_q[$];
    logic req_prev = 0, moved = 0;
    int run = 0;

    dmem_arbiter #(.MAX_CORE_BURST(4), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_mode(core_mode), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_mode(dma_mode), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_rdata(dma_rdata), .dma_done(dma_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_mode(mem_mode), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h expected %h", n, a, e);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_mem(input logic we, input logic [2:0] mode, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [7:0] len);
        mem_q.push_back({we, mode, addr, wdata, len});
    endtask

    // delay<0 means the memory never acknowledges
    always @(posedge clk) begin
        #1;
        if (mem_req) begin
            mem_ack = force_ack || (delay >= 0 && cnt == delay);
            cnt++;
        end else begin
            mem_ack = force_ack;
            cnt = 0;
        end
        mem_rdata = rd_val;
    end

    always @(negedge clk) begin
        if (core_req && !core_stall) begin
            if (core_q.size() == 0) chk("core_unexpected", 1, 0);
            else chk("core_rdata", core_rdata, core_q.pop_front());
        end
        if (dma_done) begin
            if (dma_q.size() == 0) chk("dma_unexpected", 1, 0);
            else chk("dma_rdata", dma_rdata, dma_q.pop_front());
        end
        if (mem_req && !req_prev) begin
            if (mem_q.size() == 0) begin
                chk("mem_unexpected", 1, 0);
                cur = '0;
            end else begin
                cur = mem_q.pop_front();
                chk("mem_addr", mem_addr, cur.addr);
                chk("mem_wdata", mem_wdata, cur.wdata);
                chk("mem_we_mode", {28'd0, mem_we, mem_mode}, {28'd0, cur.we, cur.mode});
            end
            run = 1;
            moved = 0;
        end else if (mem_req) begin
            run++;
            if ({mem_we, mem_mode, mem_addr, mem_wdata} !== {cur.we, cur.mode, cur.addr, cur.wdata}) moved = 1;
        end else if (req_prev) begin
            chk("mem_req_len", run, {24'd0, cur.len});
            chk("mem_stable", {31'd0, moved}, 0);
        end
        req_prev = mem_req;
    end

    // caller is at posedge+1; core_req is left high for back-to-back chaining
    task automatic core_op(input logic we, input logic [2:0] mode, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp, output int lat);
        int i;
        core_req = 1; core_we = we; core_mode = mode; core_addr = addr; core_wdata = wdata;
        core_q.push_back(exp);
        for (i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!core_stall) break;
        end
        if (i == 300) chk("core_timeout", 1, 0);
        lat = i + 1;
        tick;
    endtask

    task automatic dma_op(input logic we, input logic [2:0] mode, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp);
        int i;
        dma_req = 1; dma_we = we; dma_mode = mode; dma_addr = addr; dma_wdata = wdata;
        dma_q.push_back(exp);
        for (i = 0; i < 300; i++) begin
            tick;
            stall_seen |= core_stall;
            if (dma_done) break;
        end
        if (i == 300) chk("dma_timeout", 1, 0);
        dma_req = 0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        repeat (3) tick;
        reset = 1;
        @(negedge clk);
        chk("rst_mem_req", {31'd0, mem_req}, 0);
        chk("rst_mem_fields", {28'd0, mem_we, mem_mode} | mem_addr | mem_wdata, 0);
        chk("rst_dma_rdata", dma_rdata, 0);
        chk("rst_dma_done", {31'd0, dma_done}, 0);
        chk("rst_bus_err", {31'd0, bus_err}, 0);
        chk("rst_core_stall", {31'd0, core_stall}, 0);
        tick;

        rd_val = 32'hDEADBEEF; delay = 0;
        push_mem(0, 3'b010, 32'h100, 0, 1);
        core_op(0, 3'b010, 32'h100, 0, 32'hDEADBEEF, lat);
        core_req = 0;
        chk("core_load_latency", lat, 2);

        delay = 3; stall_seen = 0;
        push_mem(1, 3'b010, 32'h40, 32'h12345678, 4);
        dma_op(1, 3'b010, 32'h40, 32'h12345678, 0);
        chk("dma_write_no_stall", {31'd0, stall_seen}, 0);

        delay = 1; rd_val = 32'hCAFEF00D;
        push_mem(0, 3'b010, 32'h44, 0, 2);
        dma_op(0, 3'b010, 32'h44, 0, 32'hCAFEF00D);

        delay = 3; rd_val = 32'h0BADF00D;
        push_mem(0, 3'b001, 32'h48, 0, 4);
        push_mem(1, 3'b000, 32'h104, 32'hA5A5A5A5, 1);
        fork
            begin
                dma_op(0, 3'b001, 32'h48, 0, 32'h0BADF00D);
                delay = 0;
            end
            begin
                tick; tick;
                core_op(1, 3'b000, 32'h104, 32'hA5A5A5A5, 32'h0BADF00D, lat);
                core_req = 0;
            end
        join
        chk("core_behind_dma_latency", lat, 5);

        reset = 0; tick; reset = 1; tick;
        rd_val = 32'h5A5A0001; delay = 0;
`ifdef DMEM_ARB_RR_EN
        push_mem(0, 3'b100, 32'h200, 0, 1);
        push_mem(1, 3'b001, 32'h80, 32'h11110000, 1);
        push_mem(0, 3'b100, 32'h204, 0, 1);
        push_mem(1, 3'b001, 32'h84, 32'h11110001, 1);
        for (int k = 2; k < 8; k++) push_mem(0, 3'b100, 32'h200 + 32'(4 * k), 0, 1);
`else
        for (int k = 0; k < 4; k++) push_mem(0, 3'b100, 32'h200 + 32'(4 * k), 0, 1);
        push_mem(1, 3'b001, 32'h80, 32'h11110000, 1);
        for (int k = 4; k < 8; k++) push_mem(0, 3'b100, 32'h200 + 32'(4 * k), 0, 1);
        push_mem(1, 3'b001, 32'h84, 32'h11110001, 1);
`endif
        fork
            begin
                int l;
                for (int k = 0; k < 8; k++) core_op(0, 3'b100, 32'h200 + 32'(4 * k), 0, 32'h5A5A0001, l);
                core_req = 0;
            end
            begin
                for (int j = 0; j < 2; j++) dma_op(1, 3'b001, 32'h80 + 32'(4 * j), 32'h11110000 + 32'(j), 0);
            end
        join
        tick;

        delay = -1;
        push_mem(0, 3'b010, 32'h300, 0, 8);
        core_op(0, 3'b010, 32'h300, 0, 0, lat);
        core_req = 0;
        @(negedge clk);
        chk("timeout_bus_err", {31'd0, bus_err}, 1);
        chk("timeout_mem_req", {31'd0, mem_req}, 0);
        tick;
        delay = 0; rd_val = 32'h00000077;
        push_mem(0, 3'b010, 32'h304, 0, 1);
        core_op(0, 3'b010, 32'h304, 0, 32'h00000077, lat);
        core_req = 0;
        chk("after_timeout_latency", lat, 2);
        chk("bus_err_sticky", {31'd0, bus_err}, 1);

        delay = -1;
        push_mem(0, 3'b010, 32'h50, 0, 8);
        dma_op(0, 3'b010, 32'h50, 0, 0);

        push_mem(0, 3'b010, 32'h60, 0, 3);
        dma_req = 1; dma_we = 0; dma_mode = 3'b010; dma_addr = 32'h60; dma_wdata = 0;
        tick; tick; tick;
        reset = 0; dma_req = 0;
        tick;
        reset = 1; force_ack = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("mid_rst_mem_req", {31'd0, mem_req}, 0);
            chk("mid_rst_dma_done", {31'd0, dma_done}, 0);
            tick;
        end
        chk("mid_rst_bus_err", {31'd0, bus_err}, 0);
        force_ack = 0;
        repeat (3) tick;
        chk("core_q_drained", core_q.size(), 0);
        chk("dma_q_drained", dma_q.size(), 0);
        chk("mem_q_drained", mem_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
